// File: rtl/psram_pkg.sv
// psram_pkg: shared definitions for the PSRAM responder.
//   - ADDR_BITS: width of the address phase on the wire (always 24 bits).
//   - CMD_*: supported opcodes.
//   - state_t: responder protocol states.
package psram_pkg;

  localparam int ADDR_BITS = 24;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_QREAD     = 8'hEB;
  localparam logic [7:0] CMD_QWRITE    = 8'h38;
  localparam logic [7:0] CMD_QPI_EN    = 8'h35;
  localparam logic [7:0] CMD_QPI_EX    = 8'hF5;
  localparam logic [7:0] CMD_RST_EN    = 8'h66;
  localparam logic [7:0] CMD_RST       = 8'h99;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RDATA  = 3'd4,
    ST_WDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

endpackage

// File: rtl/psram_edge_sync.sv
// psram_edge_sync: two-flop synchroniser followed by an edge detector.
// Ports:
//   clk  - sampling clock
//   rst  - asynchronous active-high reset (all flops load RST_VAL)
//   din  - asynchronous input pin
//   rise - one-cycle pulse after a synchronised 0->1 transition
//   fall - one-cycle pulse after a synchronised 1->0 transition
// RST_VAL should match the idle level of the pin so that leaving reset does
// not fabricate an edge.
module psram_edge_sync
  import psram_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/psram_responder.sv
// psram_responder: device-side SPI/QPI PSRAM model driven by a controller.
// ce_n and sclk are oversampled by sys_clk; inputs are sampled on the
// synchronised sclk rise and outputs change on the synchronised sclk fall.
// Ports:
//   sys_clk   - oversampling clock (sclk phases must each be >= 4 periods)
//   sys_reset - asynchronous active-high reset
//   ce_n      - chip enable, active low
//   sclk      - serial clock from the controller
//   sio_i     - data lines in (SPI uses bit 0)
//   sio_o     - data lines out (SPI drives bit 1)
//   sio_oe    - per-line output enable, only asserted while returning data
//   qpi_mode  - 1 while QPI (4 bits per sclk) is active
//   cmd_err   - one-cycle pulse on an unsupported opcode
// Build option: define PSRAM_PAGE_WRAP_EN to make bursts wrap inside a
// PAGE_BYTES page instead of across the whole 2^ADDR_W array.
module psram_responder
  import psram_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FAST_WAIT  = 8,
  parameter int QUAD_WAIT  = 6,
  parameter int PAGE_BYTES = 1024
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic       ce_n,
  input  logic       sclk,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_o,
  output logic [3:0] sio_oe,
  output logic       qpi_mode,
  output logic       cmd_err
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef PSRAM_PAGE_WRAP_EN
  localparam bit PAGE_WRAP = 1'b1;
`else
  localparam bit PAGE_WRAP = 1'b0;
`endif

  // Bits of the address that take part in burst increments; the rest hold.
  localparam logic [ADDR_W-1:0] INC_MASK =
    PAGE_WRAP ? ADDR_W'(PAGE_BYTES - 1) : {ADDR_W{1'b1}};

  localparam logic [7:0] FAST_WAIT_C = 8'(FAST_WAIT);
  localparam logic [7:0] QUAD_WAIT_C = 8'(QUAD_WAIT);

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a & ~INC_MASK) | ((a + 1'b1) & INC_MASK);
  endfunction

  logic sclk_rise, sclk_fall, ce_rise, ce_fall;

  psram_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk  (sys_clk),
    .rst  (sys_reset),
    .din  (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  psram_edge_sync #(.RST_VAL(1'b1)) u_ce_sync (
    .clk  (sys_clk),
    .rst  (sys_reset),
    .din  (ce_n),
    .rise (ce_rise),
    .fall (ce_fall)
  );

  state_t            state;
  logic [4:0]        bit_cnt;
  logic [7:0]        wait_cnt;
  logic [7:0]        wait_len;
  logic              rd_op;
  logic [ADDR_W-1:0] addr;
  // Only ADDR_W-1 history bits are kept: together with the incoming bit that
  // is exactly the implemented address; higher wire address bits fall off.
  logic [ADDR_W-2:0] shreg;
  logic [7:0]        mem [DEPTH];

  logic [4:0]        step;
  logic [4:0]        cnt_nxt;
  logic [ADDR_W-1:0] sh_nxt;
  logic [7:0]        rd_byte;
  logic [3:0]        rd_out;
  logic              mem_we;
  logic              addr_load;
  logic              addr_adv;

  state_t            dec_state;
  logic              dec_rd;
  logic [7:0]        dec_wait;
  logic              dec_err;
  logic              dec_qpi_en;
  logic              dec_qpi_ex;

  assign rd_byte = mem[addr];

  always_comb begin
    step    = qpi_mode ? 5'd4 : 5'd1;
    cnt_nxt = bit_cnt + step;
    sh_nxt  = qpi_mode ? {shreg[ADDR_W-5:0], sio_i} : {shreg, sio_i[0]};
    // High nibble goes first in QPI; in SPI bit_cnt counts bits already sent.
    rd_out  = qpi_mode ? (bit_cnt[2] ? rd_byte[3:0] : rd_byte[7:4])
                       : {2'b00, rd_byte[~bit_cnt[2:0]], 1'b0};
  end

  always_comb begin
    mem_we    = (state == ST_WDATA) && sclk_rise && !ce_rise && (cnt_nxt == 5'd8);
    addr_load = (state == ST_ADDR) && sclk_rise && !ce_rise &&
                (cnt_nxt == 5'(ADDR_BITS));
    addr_adv  = mem_we ||
                ((state == ST_RDATA) && sclk_fall && !ce_rise && (cnt_nxt == 5'd8));
  end

  // Opcode decode on the byte completed by the current rise.
  always_comb begin
    dec_state  = ST_ADDR;
    dec_rd     = 1'b0;
    dec_wait   = 8'd0;
    dec_err    = 1'b0;
    dec_qpi_en = 1'b0;
    dec_qpi_ex = 1'b0;
    case (sh_nxt[7:0])
      CMD_READ: begin
        dec_rd = 1'b1;
      end
      CMD_FAST_READ: begin
        if (qpi_mode) begin
          dec_err   = 1'b1;
          dec_state = ST_IGNORE;
        end else begin
          dec_rd   = 1'b1;
          dec_wait = FAST_WAIT_C;
        end
      end
      CMD_WRITE: begin
        dec_rd = 1'b0;
      end
      CMD_QREAD: begin
        if (!qpi_mode) begin
          dec_err   = 1'b1;
          dec_state = ST_IGNORE;
        end else begin
          dec_rd   = 1'b1;
          dec_wait = QUAD_WAIT_C;
        end
      end
      CMD_QWRITE: begin
        if (!qpi_mode) begin
          dec_err   = 1'b1;
          dec_state = ST_IGNORE;
        end
      end
      CMD_QPI_EN: begin
        dec_qpi_en = 1'b1;
        dec_state  = ST_IGNORE;
      end
      CMD_QPI_EX: begin
        dec_qpi_ex = 1'b1;
        dec_state  = ST_IGNORE;
      end
      CMD_RST_EN, CMD_RST: begin
        dec_state = ST_IGNORE;
      end
      default: begin
        dec_err   = 1'b1;
        dec_state = ST_IGNORE;
      end
    endcase
  end

  // Storage and datapath registers carry no reset: the array must survive
  // sys_reset, and shreg/addr are always reloaded before use.
  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      mem[addr] <= sh_nxt[7:0];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sclk_rise) begin
      shreg <= sh_nxt[ADDR_W-2:0];
    end
    if (addr_load) begin
      addr <= sh_nxt;
    end else if (addr_adv) begin
      addr <= addr_inc(addr);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= 5'd0;
      wait_cnt <= 8'd0;
      wait_len <= 8'd0;
      rd_op    <= 1'b0;
      sio_o    <= 4'h0;
      sio_oe   <= 4'h0;
      qpi_mode <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (ce_rise) begin
        // Deselect ends any transfer at once; qpi_mode is sticky.
        state    <= ST_IDLE;
        bit_cnt  <= 5'd0;
        wait_cnt <= 8'd0;
        sio_o    <= 4'h0;
        sio_oe   <= 4'h0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ce_fall) begin
              state    <= ST_CMD;
              bit_cnt  <= 5'd0;
              wait_cnt <= 8'd0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              if (cnt_nxt == 5'd8) begin
                bit_cnt  <= 5'd0;
                state    <= dec_state;
                rd_op    <= dec_rd;
                wait_len <= dec_wait;
                cmd_err  <= dec_err;
                if (dec_qpi_en) qpi_mode <= 1'b1;
                if (dec_qpi_ex) qpi_mode <= 1'b0;
              end else begin
                bit_cnt <= cnt_nxt;
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise) begin
              if (cnt_nxt == 5'(ADDR_BITS)) begin
                bit_cnt <= 5'd0;
                if (!rd_op) begin
                  state <= ST_WDATA;
                end else if (wait_len != 8'd0) begin
                  state <= ST_WAIT;
                end else begin
                  state <= ST_RDATA;
                end
              end else begin
                bit_cnt <= cnt_nxt;
              end
            end
          end
          ST_WAIT: begin
            if (sclk_rise) begin
              if (8'(wait_cnt + 8'd1) == wait_len) begin
                wait_cnt <= 8'd0;
                state    <= ST_RDATA;
              end else begin
                wait_cnt <= wait_cnt + 8'd1;
              end
            end
          end
          ST_RDATA: begin
            if (sclk_fall) begin
              sio_o   <= rd_out;
              sio_oe  <= qpi_mode ? 4'hF : 4'b0010;
              bit_cnt <= (cnt_nxt == 5'd8) ? 5'd0 : cnt_nxt;
            end
          end
          ST_WDATA: begin
            if (sclk_rise) begin
              bit_cnt <= (cnt_nxt == 5'd8) ? 5'd0 : cnt_nxt;
            end
          end
          ST_IGNORE: begin
            bit_cnt <= 5'd0;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
